// File: rtl/gamma_lut_stream.sv
// Programmable per-channel gamma/tone LUT on a valid/ready pixel stream with identity fill after reset.
// Optional host table readback port is enabled by defining GAMMA_LUT_READBACK_EN.
`timescale 1ns/1ps
module gamma_lut_stream #(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 8,
  parameter int CHANNELS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*DATA_W-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHANNELS*OUT_W-1:0]    m_data,
  input  logic                         bypass,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_chan,
  input  logic [DATA_W-1:0]            cfg_addr,
  input  logic [OUT_W-1:0]             cfg_wdata,
  output logic                         cfg_busy
`ifdef GAMMA_LUT_READBACK_EN
  ,
  input  logic                         cfg_re,
  output logic [OUT_W-1:0]             cfg_rdata,
  output logic                         cfg_rvalid
`endif
);

  localparam int DEPTH = 2**DATA_W;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [DATA_W-1:0]           cnt_q, cnt_d;
  logic                        v1_q, v1_d;
  logic                        byp1_q, byp1_d;
  logic [CHANNELS*DATA_W-1:0]  pix1_q, pix1_d;
  logic                        m_valid_q, m_valid_d;
  logic [CHANNELS*OUT_W-1:0]   m_data_q, m_data_d;
  logic [CHANNELS*OUT_W-1:0]   lut_all;
  logic [CHANNELS*OUT_W-1:0]   out_word;
  logic                        run, advance, accept;
  logic [DATA_W-1:0]           waddr;
  logic [OUT_W-1:0]            wdata;

  // Scale a DATA_W code onto the OUT_W range: a * 2**OUT_W / 2**DATA_W covers both shift directions.
  function automatic logic [OUT_W-1:0] ident(input logic [DATA_W-1:0] a);
    logic [DATA_W+OUT_W-1:0] ext;
    ext = {a, {OUT_W{1'b0}}};
    return ext[DATA_W +: OUT_W];
  endfunction

  always_comb begin
    run       = (state_q == ST_RUN);
    advance   = !m_valid_q || m_ready;
    s_ready   = run && advance;
    accept    = s_valid && run && advance;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_RUN;
    end
    waddr     = run ? cfg_addr  : cnt_q;
    wdata     = run ? cfg_wdata : ident(cnt_q);
    v1_d      = advance ? accept : v1_q;
    byp1_d    = accept ? bypass : byp1_q;
    pix1_d    = accept ? s_data : pix1_q;
    out_word  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_word[c*OUT_W +: OUT_W] = byp1_q ? ident(pix1_q[c*DATA_W +: DATA_W])
                                          : lut_all[c*OUT_W +: OUT_W];
    end
    m_valid_d = advance ? v1_q : m_valid_q;
    m_data_d  = (advance && v1_q) ? out_word : m_data_q;
  end

`ifdef GAMMA_LUT_READBACK_EN
  logic [4*OUT_W-1:0] rb_all;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         rchan_q, rchan_d;
`endif

  // Per-channel table: INIT fills every channel at once, RUN takes host writes; reads see old data.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [OUT_W-1:0] mem [DEPTH];
    logic [OUT_W-1:0] rd_q;
    logic             we;
    assign we = run ? (cfg_we && (cfg_chan == 2'(c))) : 1'b1;
`ifdef GAMMA_LUT_READBACK_EN
    logic [OUT_W-1:0] rb_q;
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (accept) rd_q <= mem[s_data[c*DATA_W +: DATA_W]];
      if (cfg_re && run) rb_q <= mem[cfg_addr];
    end
    assign rb_all[c*OUT_W +: OUT_W] = rb_q;
`else
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (accept) rd_q <= mem[s_data[c*DATA_W +: DATA_W]];
    end
`endif
    assign lut_all[c*OUT_W +: OUT_W] = rd_q;
  end

`ifdef GAMMA_LUT_READBACK_EN
  for (genvar c = CHANNELS; c < 4; c++) begin : g_rb_pad
    assign rb_all[c*OUT_W +: OUT_W] = '0;
  end

  always_comb begin
    rvalid_d = run && cfg_re;
    rchan_d  = cfg_chan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rchan_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rchan_q  <= rchan_d;
    end
  end

  assign cfg_rvalid = rvalid_q;
  assign cfg_rdata  = rvalid_q ? rb_all[int'(rchan_q)*OUT_W +: OUT_W] : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      v1_q      <= 1'b0;
      byp1_q    <= 1'b0;
      pix1_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      v1_q      <= v1_d;
      byp1_q    <= byp1_d;
      pix1_q    <= pix1_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign cfg_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_gamma_lut_stream.sv
// Self-checking bench for gamma_lut_stream: randomized streams against a transaction-level table model.
`timescale 1ns/1ps
module tb_gamma_lut_stream;

  localparam int DW = 8;
  localparam int OW = 8;
  localparam int CH = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [CH*DW-1:0]  s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [CH*OW-1:0]  m_data;
  logic              bypass = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_chan = '0;
  logic [DW-1:0]     cfg_addr = '0;
  logic [OW-1:0]     cfg_wdata = '0;
  logic              cfg_busy;

  int checks = 0;
  int errors = 0;

  int          tbl [CH][256];
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  logic        smp_accept;
  logic        smp_m_valid;
  logic        smp_m_ready;
  logic [23:0] smp_m_data;

  gamma_lut_stream #(.DATA_W(DW), .OUT_W(OW), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .bypass(bypass), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void model_reset();
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < 256; a++) tbl[c][a] = a;
  endfunction

  function automatic logic [23:0] model_pix(input logic [23:0] d, input logic byp);
    logic [23:0] r;
    logic [7:0]  v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      v = d[c*8 +: 8];
      r[c*8 +: 8] = byp ? v : 8'(tbl[c][v]);
    end
    return r;
  endfunction

  // One clock: sample mid-cycle, record accepted pixels (table read before same-cycle write) and outputs.
  task automatic tick();
    @(negedge clk);
    smp_accept  = s_valid && s_ready;
    smp_m_valid = m_valid;
    smp_m_ready = m_ready;
    smp_m_data  = m_data;
    if (smp_accept) exp_q.push_back(model_pix(s_data, bypass));
    if (cfg_we && cfg_chan < CH) tbl[cfg_chan][cfg_addr] = int'(cfg_wdata);
    if (m_valid && m_ready) obs_q.push_back(m_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int busy_cnt, viol;
    bit done;
    #2;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 24'h0) begin errors++; $display("[TB] FAIL reset_m_data: got %h expected 000000", m_data); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_cfg_busy: got %b expected 1", cfg_busy); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b1; s_data = 24'h101010; m_ready = 1'b1;
    busy_cnt = 0; viol = 0; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (cfg_busy) begin
        busy_cnt++;
        if (s_ready) viol++;
      end else done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL init_timeout: busy never dropped"); end
    checks++; if (busy_cnt != 256) begin errors++; $display("[TB] FAIL init_length: got %0d expected 256", busy_cnt); end
    checks++; if (viol != 0) begin errors++; $display("[TB] FAIL init_s_ready: s_ready high on %0d busy cycles expected 0", viol); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL run_s_ready: got %b expected 1", s_ready); end
    @(posedge clk); #1; s_data = 24'h202020;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: m_valid %b expected 0", m_valid); end
    @(posedge clk); #1; s_data = 24'h303030;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 24'h101010) begin errors++; $display("[TB] FAIL first_pixel: got v=%b %h expected v=1 101010", m_valid, m_data); end
    @(posedge clk); #1; s_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 24'h202020) begin errors++; $display("[TB] FAIL second_pixel: got v=%b %h expected v=1 202020", m_valid, m_data); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 24'h303030) begin errors++; $display("[TB] FAIL third_pixel: got v=%b %h expected v=1 303030", m_valid, m_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_table();
    exp_q.delete(); obs_q.delete();
    cfg_we = 1'b1; cfg_chan = 2'd0;
    for (int a = 0; a < 256; a++) begin
      cfg_addr = 8'(a); cfg_wdata = 8'(255 - a);
      tick();
    end
    cfg_we = 1'b0;
    s_valid = 1'b1; s_data = 24'h776605; bypass = 1'b0; m_ready = 1'b1;
    tick();
    drain(4);
    checks++; if (obs_q.size() != 1) begin errors++; $display("[TB] FAIL load_count: got %0d expected 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== 24'h7766FA) begin errors++; $display("[TB] FAIL load_value: got %h expected 7766fa", obs_q[0]); end
    end
  endtask

  task automatic test_stream();
    int sent, cyc;
    logic prev_v, prev_r;
    logic [23:0] prev_d;
    exp_q.delete(); obs_q.delete();
    sent = 0; cyc = 0; prev_v = 0; prev_r = 1; prev_d = '0;
    s_valid = 1'b1; s_data = 24'($urandom); bypass = 1'($urandom);
    while ((sent < 64 || obs_q.size() < 64) && cyc < 2000) begin
      m_ready = 1'($urandom);
      tick();
      cyc++;
      if (prev_v && !prev_r) begin
        checks++;
        if (smp_m_valid !== 1'b1 || smp_m_data !== prev_d) begin
          errors++; $display("[TB] FAIL stall_hold: got v=%b %h expected v=1 %h", smp_m_valid, smp_m_data, prev_d);
        end
      end
      prev_v = smp_m_valid; prev_r = smp_m_ready; prev_d = smp_m_data;
      if (smp_accept) begin
        sent++;
        if (sent < 64) begin s_data = 24'($urandom); bypass = 1'($urandom); end
        else s_valid = 1'b0;
      end
    end
    checks++; if (cyc >= 2000) begin errors++; $display("[TB] FAIL stream_timeout: sent %0d got %0d", sent, obs_q.size()); end
    checks++; if (obs_q.size() != 64) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 64", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stream_pixel[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    m_ready = 1'b1; bypass = 1'b0;
  endtask

  task automatic test_write_collision();
    exp_q.delete(); obs_q.delete();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 24'h114005; bypass = 1'b0;
    cfg_we = 1'b1; cfg_chan = 2'd1; cfg_addr = 8'h40; cfg_wdata = 8'h99;
    tick();
    checks++; if (smp_accept !== 1'b1) begin errors++; $display("[TB] FAIL collide_accept: got %b expected 1", smp_accept); end
    cfg_we = 1'b0;
    tick();
    drain(4);
    checks++; if (obs_q.size() != 2) begin errors++; $display("[TB] FAIL collide_count: got %0d expected 2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== 24'h1140FA) begin errors++; $display("[TB] FAIL collide_old: got %h expected 1140fa", obs_q[0]); end
      checks++; if (obs_q[1] !== 24'h1199FA) begin errors++; $display("[TB] FAIL collide_new: got %h expected 1199fa", obs_q[1]); end
    end
  endtask

  task automatic test_bypass();
    exp_q.delete(); obs_q.delete();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 24'h5A4033; bypass = 1'b1;
    tick();
    drain(4);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 24'h5A4033) begin
      errors++; $display("[TB] FAIL bypass_single: got n=%0d %h expected n=1 5a4033", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 24'h0);
    end
    exp_q.delete(); obs_q.delete();
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bypass = 1'(i);
      s_data = 24'($urandom);
      tick();
      checks++; if (smp_accept !== 1'b1) begin errors++; $display("[TB] FAIL bypass_throughput[%0d]: accept %b expected 1", i, smp_accept); end
    end
    drain(4);
    bypass = 1'b0;
    checks++; if (obs_q.size() != 16) begin errors++; $display("[TB] FAIL bypass_count: got %0d expected 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL bypass_toggle[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    bit done;
    exp_q.delete(); obs_q.delete();
    m_ready = 1'b0; s_valid = 1'b1; bypass = 1'b0;
    s_data = 24'h123456; tick();
    s_data = 24'h654321; tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_inflight: m_valid %b expected 1", m_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_m_valid: got %b expected 0", m_valid); end
    checks++; if (cfg_busy !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_state: busy %b ready %b expected 1 0", cfg_busy, s_ready); end
    s_valid = 1'b0;
    exp_q.delete(); obs_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; m_ready = 1'b1;
    stale = 0; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (m_valid) stale++;
      if (!cfg_busy) done = 1;
    end
    checks++; if (!done || stale != 0) begin errors++; $display("[TB] FAIL midrst_refill: done %b stale %0d expected 1 0", done, stale); end
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 24'h774005;
    tick();
    drain(4);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 24'h774005) begin
      errors++; $display("[TB] FAIL midrst_identity: got n=%0d %h expected n=1 774005", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 24'h0);
    end
  endtask

  initial begin
    test_reset();
    test_load_table();
    test_stream();
    test_write_collision();
    test_bypass();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
